// File: rtl/demux8_pkg.sv
// Shared widths and the controller state type for the 8-way demux sequencer.
package demux8_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DROP_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set bit of mask searching from start upward, wrapping mod 8.
module rr_pick8
  import demux8_pkg::*;
(
  input  logic [LANES-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      cand = start + SEL_W'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux8_sequencer.sv
// Steers a valid/ready word stream onto one of eight lanes, round-robin or addressed,
// holding one word at a time and counting words dropped for lack of an enabled target.
module demux8_sequencer
  import demux8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [LANES-1:0] lane_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_dest,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [LANES-1:0]  valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic             complete;
  logic             accept;
  logic [SEL_W-1:0] rr_start;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic             has_target;
  logic [SEL_W-1:0] target;

  // Handshake and target resolution; a word accepted on a completion cycle searches from sel+1.
  always_comb begin
    complete   = (state_q == HOLD) && out_ready[sel_q];
    in_ready   = (state_q == IDLE) || complete;
    accept     = in_valid && in_ready;
    rr_start   = complete ? (sel_q + SEL_W'(1)) : ptr_q;
    has_target = mode ? lane_en[in_dest] : rr_found;
    target     = mode ? in_dest : rr_idx;
  end

  rr_pick8 u_rr_pick8 (
    .mask  (lane_en),
    .start (rr_start),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    drop_d  = drop_q;

    if (complete) begin
      ptr_d   = sel_q + SEL_W'(1);
      state_d = IDLE;
    end

    if (accept) begin
      if (has_target) begin
        state_d = HOLD;
        sel_d   = target;
        data_d  = in_data;
      end else if (drop_q != {DROP_W{1'b1}}) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end

    valid_d = (state_d == HOLD) ? (LANES'(1) << sel_d) : '0;
    busy_d  = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux8_sequencer.sv
// Scoreboard bench: the driver queues hand-computed lane/data per accepted word, a monitor checks each delivery.
module tb_demux8_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [7:0] lane_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [2:0] lane;
    logic [7:0] data;
    bit         lat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  demux8_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .lane_en   (lane_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a word, wait (bounded) for acceptance, queue the expected delivery unless lane < 0.
  task automatic send(input logic [7:0] d, input logic [2:0] dest, input int lane,
                      input bit lat, output int waited);
    exp_t e;
    in_data  = d;
    in_dest  = dest;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    if (lane >= 0) begin
      e.lane = 3'(lane);
      e.data = d;
      e.lat  = lat;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: a delivery completes at the next edge whenever out_ready[sel] is high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid != 8'h00 && out_ready[sel]) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", int'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("lane_sel", int'(sel), int'(e.lane));
        chk("onehot", int'(out_valid), int'(8'h01 << e.lane));
        chk("data", int'(out_data), int'(e.data));
        chk("busy", int'(busy), 1);
        if (e.lat) chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    int w;
    int lanes_sparse[4] = '{0, 2, 7, 0};
    int lanes_mask[8]   = '{6, 7, 0, 1, 2, 3, 4, 6};

    rst = 1'b1; mode = 1'b0; lane_en = 8'hFF; in_valid = 1'b0;
    in_data = '0; in_dest = '0; out_ready = 8'hFF;
    pulse_reset();

    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Round-robin over all lanes, back to back.
    for (int i = 0; i < 10; i++) begin
      send(8'(i), 3'd0, i % 8, 1'b1, w);
      chk("rr_in_ready", w, 0);
    end
    idle();
    repeat (3) @(posedge clk); #1;

    // Sparse mask with wrap, starting from a fresh pointer.
    pulse_reset();
    lane_en = 8'b1000_0101;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 3'd0, lanes_sparse[i], 1'b0, w);
    idle();
    repeat (3) @(posedge clk); #1;

    // Pointer wrap: complete on lane 6 so ptr=7, then only lane 0 enabled.
    mode = 1'b1; lane_en = 8'hFF;
    send(8'h36, 3'd6, 6, 1'b0, w);
    mode = 1'b0; lane_en = 8'h01;
    send(8'h30, 3'd0, 0, 1'b0, w);
    idle();
    repeat (3) @(posedge clk); #1;

    // Addressed to a disabled lane: everything dropped, counter saturates.
    mode = 1'b1; lane_en = 8'b1111_1110;
    for (int i = 0; i < 260; i++) begin
      send(8'(i), 3'd0, -1, 1'b0, w);
      if (i == 99) chk("drop_cnt_100", int'(drop_cnt), 100);
    end
    idle();
    chk("drop_cnt_sat", int'(drop_cnt), 255);
    repeat (2) @(posedge clk); #1;
    chk("drop_cnt_hold", int'(drop_cnt), 255);

    // Backpressure on lane 3 with the next word waiting.
    lane_en = 8'hFF; out_ready = 8'hF7;
    send(8'hA5, 3'd3, 3, 1'b0, w);
    in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_data_stable", int'(out_data), 8'hA5);
      chk("bp_out_valid", int'(out_valid), 8'h08);
      @(posedge clk); #1;
    end
    out_ready = 8'hFF;
    send(8'h5A, 3'd3, 3, 1'b0, w);
    chk("bp_same_cycle_accept", w, 0);
    idle();
    repeat (3) @(posedge clk); #1;

    // Reset while holding a word for lane 4.
    out_ready = 8'hEF;
    send(8'h77, 3'd4, 4, 1'b0, w);
    idle();
    @(negedge clk);
    chk("hold_out_valid", int'(out_valid), 8'h10);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_drop_cnt", int'(drop_cnt), 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 8'hFF; mode = 1'b0; lane_en = 8'hFF;
    send(8'h11, 3'd0, 0, 1'b0, w);
    idle();
    repeat (3) @(posedge clk); #1;

    // Mask change while holding for lane 5.
    mode = 1'b1; out_ready = 8'hDF;
    send(8'h55, 3'd5, 5, 1'b0, w);
    idle();
    @(negedge clk);
    chk("mask_hold_valid", int'(out_valid), 8'h20);
    @(posedge clk); #1 lane_en = 8'hDF;
    @(posedge clk); #1 out_ready = 8'hFF; mode = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 3'd0, lanes_mask[i], 1'b0, w);
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
